writeback_unit: RTL and testbench

- Writer end of the register bank write port: owns the (rd, data, enable) stream into the 32x32 register file.
- Merges single-cycle ALU results with multi-cycle load returns from data memory.
- Applies RV32I load extraction and suppresses x0 writes.
- Exports a busy scoreboard so decode can stall on pending load destinations.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/writeback_unit_if.sv | 31 +++
 rtl/load_extract.sv | 30 +++
 rtl/writeback_unit.sv | 144 ++++++++++++++
 tb/tb_writeback_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I load codes, datapath width and load tracker states
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ld_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - ALU, load issue, memory return and register write port bundle
interface writeback_unit_if #(parameter int XLEN = 32);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_result;
  logic            ld_issue_valid;
  logic            ld_issue_ready;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_byte_off;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [31:0]     busy;
  logic            load_fault;

  modport master (
    output alu_valid, alu_rd, alu_result, ld_issue_valid, ld_rd, ld_funct3, ld_byte_off,
           mem_rvalid, mem_rdata,
    input  alu_ready, ld_issue_ready, wb_en, wb_rd, wb_data, busy, load_fault
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result, ld_issue_valid, ld_rd, ld_funct3, ld_byte_off,
           mem_rvalid, mem_rdata,
    output alu_ready, ld_issue_ready, wb_en, wb_rd, wb_data, busy, load_fault
  );
endinterface

// File: rtl/load_extract.sv
// rtl/load_extract.sv - RV32I load byte/halfword/word extraction from an aligned word
module load_extract
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[{byte_off, 3'b000} +: 8];
    sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    data     = '0;
    illegal  = 1'b0;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LH:   data = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LW:   data = rdata;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, sel_half};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register write port arbiter merging ALU results and load returns
module writeback_unit #(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic             stage_clk,
  input  logic             reset,
  writeback_unit_if.slave  wbi
);
  import riscv_pkg::*;

  localparam int CW = $clog2(LOAD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  ld_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic            skid_valid_q, skid_valid_d;
  logic [4:0]      skid_rd_q, skid_rd_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [31:0]     busy_q, busy_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] ext_data;
  logic            ext_illegal;
  logic            ld_accept, ld_ret, ld_tmo, alu_acc;

  load_extract u_extract (
    .funct3   (funct3_q),
    .byte_off (off_q),
    .rdata    (wbi.mem_rdata),
    .data     (ext_data),
    .illegal  (ext_illegal)
  );

  assign ld_accept = wbi.ld_issue_valid && (state_q == IDLE);
  assign ld_ret    = (state_q == WAIT) && wbi.mem_rvalid;
  assign ld_tmo    = (state_q == WAIT) && !wbi.mem_rvalid && (cnt_q == CNT_LAST);
  assign alu_acc   = wbi.alu_valid && !skid_valid_q;

  always_ff @(posedge stage_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ld_rd_q      <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_data_q  <= '0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      busy_q       <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_rd_q      <= ld_rd_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_data_q  <= skid_data_d;
      wb_en_q      <= wb_en_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (ld_accept) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (ld_ret || ld_tmo) state_d = IDLE;
            else cnt_d = cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end

  // Port priority: load return, then skid drain, then a fresh ALU result.
  always_comb begin
    ld_rd_d     = ld_accept ? wbi.ld_rd       : ld_rd_q;
    funct3_d    = ld_accept ? wbi.ld_funct3   : funct3_q;
    off_d       = ld_accept ? wbi.ld_byte_off : off_q;
    skid_valid_d = skid_valid_q;
    skid_rd_d   = skid_rd_q;
    skid_data_d = skid_data_q;
    wb_en_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    fault_d     = ld_tmo || (ld_ret && ext_illegal);
    busy_d      = busy_q;
    if (ld_accept) busy_d[wbi.ld_rd] = 1'b1;
    if (ld_ret || ld_tmo) busy_d[ld_rd_q] = 1'b0;
    busy_d[0] = 1'b0;

    if (ld_ret) begin
      if (!ext_illegal && ld_rd_q != 5'd0) begin
        wb_en_d   = 1'b1;
        wb_rd_d   = ld_rd_q;
        wb_data_d = ext_data;
      end
      if (alu_acc) begin
        skid_valid_d = 1'b1;
        skid_rd_d    = wbi.alu_rd;
        skid_data_d  = wbi.alu_result;
      end
    end else if (skid_valid_q) begin
      skid_valid_d = 1'b0;
      if (skid_rd_q != 5'd0) begin
        wb_en_d   = 1'b1;
        wb_rd_d   = skid_rd_q;
        wb_data_d = skid_data_q;
      end
    end else if (alu_acc && wbi.alu_rd != 5'd0) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = wbi.alu_rd;
      wb_data_d = wbi.alu_result;
    end
  end

  always_comb begin
    wbi.ld_issue_ready = (state_q == IDLE);
    wbi.alu_ready      = !skid_valid_q;
    wbi.wb_en          = wb_en_q;
    wbi.wb_rd          = wb_rd_q;
    wbi.wb_data        = wb_data_q;
    wbi.busy           = busy_q;
    wbi.load_fault     = fault_q;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses;

  writeback_unit_if #(.XLEN(32)) wbi ();

  writeback_unit #(.XLEN(32), .LOAD_TIMEOUT(16)) dut (
    .stage_clk (clk),
    .reset     (rst_n),
    .wbi       (wbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
    wbi.ld_issue_valid = 1'b1;
    wbi.ld_rd          = rd;
    wbi.ld_funct3      = f3;
    wbi.ld_byte_off    = off;
    tick();
    wbi.ld_issue_valid = 1'b0;
  endtask

  task automatic ret(input logic [31:0] rdata);
    wbi.mem_rvalid = 1'b1;
    wbi.mem_rdata  = rdata;
    tick();
    wbi.mem_rvalid = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] off, input logic [31:0] exp);
    issue(rd, f3, off);
    chk({tag, "_busy_set"}, wbi.busy, 32'h1 << rd);
    chk({tag, "_issue_rdy0"}, {31'd0, wbi.ld_issue_ready}, 32'd0);
    tick();
    ret(32'h80FF_1234);
    chk({tag, "_wb_en"}, {31'd0, wbi.wb_en}, 32'd1);
    chk({tag, "_wb_rd"}, {27'd0, wbi.wb_rd}, {27'd0, rd});
    chk({tag, "_wb_data"}, wbi.wb_data, exp);
    chk({tag, "_busy_clr"}, wbi.busy, 32'd0);
    chk({tag, "_issue_rdy1"}, {31'd0, wbi.ld_issue_ready}, 32'd1);
  endtask

  initial begin
    rst_n              = 1'b0;
    wbi.alu_valid      = 1'b0;
    wbi.alu_rd         = '0;
    wbi.alu_result     = '0;
    wbi.ld_issue_valid = 1'b0;
    wbi.ld_rd          = '0;
    wbi.ld_funct3      = '0;
    wbi.ld_byte_off    = '0;
    wbi.mem_rvalid     = 1'b0;
    wbi.mem_rdata      = '0;
    #12;
    chk("rst_wb_en", {31'd0, wbi.wb_en}, 32'd0);
    chk("rst_wb_rd", {27'd0, wbi.wb_rd}, 32'd0);
    chk("rst_wb_data", wbi.wb_data, 32'd0);
    chk("rst_busy", wbi.busy, 32'd0);
    chk("rst_fault", {31'd0, wbi.load_fault}, 32'd0);
    chk("rst_issue_rdy", {31'd0, wbi.ld_issue_ready}, 32'd1);
    chk("rst_alu_rdy", {31'd0, wbi.alu_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // plain ALU write
    wbi.alu_valid  = 1'b1;
    wbi.alu_rd     = 5'd5;
    wbi.alu_result = 32'hDEAD_BEEF;
    tick();
    wbi.alu_valid = 1'b0;
    chk("alu_wb_en", {31'd0, wbi.wb_en}, 32'd1);
    chk("alu_wb_rd", {27'd0, wbi.wb_rd}, 32'd5);
    chk("alu_wb_data", wbi.wb_data, 32'hDEAD_BEEF);
    chk("alu_ready", {31'd0, wbi.alu_ready}, 32'd1);
    tick();
    chk("alu_wb_en_drop", {31'd0, wbi.wb_en}, 32'd0);
    chk("alu_wb_data_hold", wbi.wb_data, 32'hDEAD_BEEF);

    // load extraction on 0x80FF_1234
    load_case("lb3",  5'd7, 3'b000, 2'd3, 32'hFFFF_FF80);
    load_case("lbu3", 5'd7, 3'b100, 2'd3, 32'h0000_0080);
    load_case("lhu2", 5'd7, 3'b101, 2'd2, 32'h0000_80FF);
    load_case("lh2",  5'd8, 3'b001, 2'd2, 32'hFFFF_80FF);
    load_case("lh0",  5'd8, 3'b001, 2'd0, 32'h0000_1234);
    load_case("lb1",  5'd8, 3'b000, 2'd1, 32'h0000_0012);
    load_case("lw",   5'd8, 3'b010, 2'd0, 32'h80FF_1234);

    // load return and ALU result collide
    issue(5'd3, 3'b010, 2'd0);
    tick();
    wbi.mem_rvalid = 1'b1;
    wbi.mem_rdata  = 32'h0000_0033;
    wbi.alu_valid  = 1'b1;
    wbi.alu_rd     = 5'd4;
    wbi.alu_result = 32'h0000_0011;
    tick();
    wbi.mem_rvalid = 1'b0;
    wbi.alu_rd     = 5'd6;
    wbi.alu_result = 32'h0000_0066;
    chk("mrg1_wb_rd", {27'd0, wbi.wb_rd}, 32'd3);
    chk("mrg1_wb_data", wbi.wb_data, 32'h33);
    chk("mrg1_alu_rdy", {31'd0, wbi.alu_ready}, 32'd0);
    tick();
    chk("mrg2_wb_en", {31'd0, wbi.wb_en}, 32'd1);
    chk("mrg2_wb_rd", {27'd0, wbi.wb_rd}, 32'd4);
    chk("mrg2_wb_data", wbi.wb_data, 32'h11);
    chk("mrg2_alu_rdy", {31'd0, wbi.alu_ready}, 32'd1);
    tick();
    wbi.alu_valid = 1'b0;
    chk("mrg3_wb_rd", {27'd0, wbi.wb_rd}, 32'd6);
    chk("mrg3_wb_data", wbi.wb_data, 32'h66);
    tick();
    chk("mrg4_wb_en", {31'd0, wbi.wb_en}, 32'd0);

    // timeout: 16 waiting cycles, fault on the edge that ends the last one
    issue(5'd9, 3'b010, 2'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (wbi.load_fault) pulses++;
    end
    chk("tmo_early_fault", pulses, 0);
    chk("tmo_busy_held", wbi.busy, 32'h1 << 9);
    tick();
    chk("tmo_fault", {31'd0, wbi.load_fault}, 32'd1);
    chk("tmo_busy_clr", wbi.busy, 32'd0);
    chk("tmo_no_wb", {31'd0, wbi.wb_en}, 32'd0);
    chk("tmo_issue_rdy", {31'd0, wbi.ld_issue_ready}, 32'd1);
    ret(32'h1234_5678);
    chk("tmo_fault_once", {31'd0, wbi.load_fault}, 32'd0);
    chk("tmo_late_rvalid", {31'd0, wbi.wb_en}, 32'd0);

    // x0 targets
    wbi.alu_valid  = 1'b1;
    wbi.alu_rd     = 5'd0;
    wbi.alu_result = 32'hFFFF_FFFF;
    tick();
    wbi.alu_valid = 1'b0;
    chk("x0_alu_wb_en", {31'd0, wbi.wb_en}, 32'd0);
    chk("x0_alu_wb_rd_hold", {27'd0, wbi.wb_rd}, 32'd6);
    issue(5'd0, 3'b010, 2'd0);
    chk("x0_ld_busy", wbi.busy, 32'd0);
    ret(32'hAAAA_AAAA);
    chk("x0_ld_wb_en", {31'd0, wbi.wb_en}, 32'd0);
    chk("x0_ld_issue_rdy", {31'd0, wbi.ld_issue_ready}, 32'd1);

    // illegal funct3
    issue(5'd10, 3'b011, 2'd0);
    chk("ill_busy_set", wbi.busy, 32'h1 << 10);
    ret(32'h5555_5555);
    chk("ill_fault", {31'd0, wbi.load_fault}, 32'd1);
    chk("ill_no_wb", {31'd0, wbi.wb_en}, 32'd0);
    chk("ill_busy_clr", wbi.busy, 32'd0);

    // async reset during a pending load
    issue(5'd12, 3'b010, 2'd0);
    chk("ar_busy_set", wbi.busy, 32'h1 << 12);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy_clr", wbi.busy, 32'd0);
    chk("ar_wb_data", wbi.wb_data, 32'd0);
    chk("ar_issue_rdy", {31'd0, wbi.ld_issue_ready}, 32'd1);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_issue_rdy_rel", {31'd0, wbi.ld_issue_ready}, 32'd1);
    ret(32'hCAFE_F00D);
    chk("ar_stale_rvalid", {31'd0, wbi.wb_en}, 32'd0);
    chk("ar_stale_busy", wbi.busy, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
